ucsbece154b_icache: RTL and testbench
=====================================

// Module: ucsbece154b_icache
// PURPOSE
//  Direct-mapped, read-only instruction cache between the pipelined core's fetch stage and a
//  slow, burst-read instruction memory. Returns hits in the same cycle. Refills a whole line on a miss.
//  Stalls fetch through Busy until the missed word is delivered.
// PARAMETERS
//  NUM_SETS     8   lines, power of 2, >=2; INDEX_W = log2(NUM_SETS)
//  BLOCK_WORDS  4   32-bit words per line, power of 2, >=2; OFS_W = log2(BLOCK_WORDS)
//  TAG_W        30-INDEX_W-OFS_W  derived localparam, not overridable
// PORTS
//  clk             in   1   single clock, all state on posedge
//  reset           in   1   one clock; reset is asynchronous and active-low
//  ReadEnable      in   1   fetch requests ReadAddress this cycle
//  ReadAddress     in   32  byte address; [1:0] ignored
//  Flush           in   1   fence.i: invalidate every line
//  Instruction     out  32  instruction word; valid when Ready=1
//  Ready           out  1   Instruction valid this cycle
//  Busy            out  1   miss in progress; fetch must stall and hold ReadAddress
//  MemReadAddress  out  32  line-aligned byte address of the refill
//  MemReadRequest  out  1   refill request, held until the first beat
//  MemDataIn       in   32  refill beat data
//  MemDataReady    in   1   MemDataIn valid; BLOCK_WORDS beats in ascending word order
//  HitCount        out  32  saturating hit counter
//  MissCount       out  32  saturating miss counter
// BEHAVIOUR
//  reset=0 (async): all valid bits=0, FSM=IDLE, counters=0, beat counter=0, flush_pending=0.
//   Outputs while in reset: Ready=0, Busy=0, MemReadRequest=0, MemReadAddress=0, Instruction=0.
//  Address split: tag=[31:2+OFS_W+INDEX_W], index=[2+OFS_W+INDEX_W-1:2+OFS_W], ofs=[2+OFS_W-1:2].
//  IDLE:
//   - ReadEnable && hit: Ready=1 combinationally, Instruction=data[index][ofs], HitCount++.
//     Zero-cycle latency.
//   - ReadEnable && miss: Ready=0, Busy=1 combinationally. Latch the address. MissCount++.
//     Go to REQ.
//   - ReadEnable=0: Ready=0, Busy=0, no counter change.
//  REQ:
//   - MemReadRequest=1; MemReadAddress={latched[31:2+OFS_W], 0}; Busy=1.
//   - A beat arriving while in REQ is captured as word 0. Go to FILL.
//  FILL:
//   - Busy=1, MemReadRequest=0.
//   - Each MemDataReady writes beat k into data[index][k]; k increments.
//   - When beat BLOCK_WORDS-1 is written, set tag and valid=!flush_pending. Go to DONE.
//   - Cycles with MemDataReady=0 are wait states; the FSM stays in FILL.
//  DONE (one cycle):
//   - Ready=1, Busy=0, Instruction=word[latched ofs] from the fill.
//   - If flush_pending: clear all valid bits and flush_pending. Go to IDLE.
//   - HitCount does not increment.
//  Flush:
//   - In IDLE: all valid bits cleared at the next edge. A same-cycle lookup uses the pre-flush
//     state and may hit.
//   - In REQ/FILL/DONE: sets flush_pending. The refill still completes, but the line is left invalid.
//  ReadAddress changes during Busy are ignored; only the latched address is served.
//  MemDataReady in IDLE or DONE is ignored.
//  Counters saturate at 32'hFFFF_FFFF.
//  Reset mid-refill: the FSM aborts to IDLE and no partial line becomes valid.
//   Beats still in flight after reset release are ignored in IDLE.
// STRUCTURE
//  Shared package ucsbece154b_icache_pkg: FSM state encodings (IDLE/REQ/FILL/DONE, 2 bits) and
//   the address-field width localparams.
//  One sub-module, ucsbece154b_icache_array: tag/valid/data storage.
//   Async read; sync write of one word plus tag/valid; single-cycle clear-all-valid.
//   Async clear on reset.
//  The top holds the FSM, the address latch, the beat counter, flush_pending and the counters.
// TESTING
//  1 reset=0 for 2 cycles, then read 0x00 -> Busy=1, MemReadRequest=1 with MemReadAddress=0x00.
//    Supply 4 beats 0xA0..0xA3 -> DONE: Ready=1, Instruction=0xA0. MissCount=1.
//  2 Then read 0x08 -> same-cycle Ready=1, Instruction=0xA2, HitCount=1, no memory request.
//  3 Read 0x80 (same index as 0x00 at defaults, different tag) -> miss, line refilled.
//    A later read of 0x00 misses again (conflict eviction). MissCount=3.
//  4 Miss on 0x14 with 2-cycle wait states between beats -> Ready only in DONE,
//    Instruction=beat1. ReadAddress toggled during Busy has no effect.
//  5 Flush asserted during FILL -> DONE still returns the correct word, but the next read of the
//    same address misses. Flush in IDLE -> all prior lines miss.
//  6 reset=0 after 2 of 4 beats -> after release: Busy=0. Leftover MemDataReady pulses are
//    ignored. A read of the same line misses and fetches a fresh line (no stale data).

Source files
------------

// File: rtl/ucsbece154b_icache_pkg.sv
// ----------------------------------------------------------------------------
// ucsbece154b_icache_pkg
// Shared definitions for the direct-mapped instruction cache:
//   - state_t       : refill FSM encoding (IDLE/REQ/FILL/DONE, 2 bits)
//   - address-field widths for the default geometry
//   - tag_width()   : tag width derived from index and offset widths
// No ports (package).
// ----------------------------------------------------------------------------
package ucsbece154b_icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int ADDR_W      = 32;
    localparam int WORD_W      = 32;
    localparam int BYTE_OFS_W  = 2;   // byte-in-word bits, always ignored

    localparam int DEF_NUM_SETS    = 8;
    localparam int DEF_BLOCK_WORDS = 4;
    localparam int DEF_INDEX_W     = $clog2(DEF_NUM_SETS);
    localparam int DEF_OFS_W       = $clog2(DEF_BLOCK_WORDS);

    // Tag is everything above the index field.
    function automatic int tag_width(input int index_w, input int ofs_w);
        return ADDR_W - BYTE_OFS_W - index_w - ofs_w;
    endfunction

    localparam int DEF_TAG_W = tag_width(DEF_INDEX_W, DEF_OFS_W);

endpackage

// File: rtl/ucsbece154b_icache_array.sv
// ----------------------------------------------------------------------------
// ucsbece154b_icache_array
// Tag / valid / data storage for the direct-mapped instruction cache.
//   clk, reset          : clock, asynchronous active-low reset (clears valid)
//   rd_index, rd_ofs    : combinational lookup address
//   rd_tag, rd_valid,
//   rd_data             : asynchronous read results
//   wr_en, wr_index,
//   wr_ofs, wr_data     : one-word synchronous data write
//   line_wr_en,
//   line_wr_valid,
//   line_tag            : synchronous tag write and valid update for wr_index
//   clear_all           : invalidate every line at the next edge
// ----------------------------------------------------------------------------
module ucsbece154b_icache_array
    import ucsbece154b_icache_pkg::*;
#(
    parameter int NUM_SETS    = DEF_NUM_SETS,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int TAG_W       = DEF_TAG_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [$clog2(NUM_SETS)-1:0]    rd_index,
    input  logic [$clog2(BLOCK_WORDS)-1:0] rd_ofs,
    output logic [TAG_W-1:0]               rd_tag,
    output logic                           rd_valid,
    output logic [WORD_W-1:0]              rd_data,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_SETS)-1:0]    wr_index,
    input  logic [$clog2(BLOCK_WORDS)-1:0] wr_ofs,
    input  logic [WORD_W-1:0]              wr_data,
    input  logic                           line_wr_en,
    input  logic                           line_wr_valid,
    input  logic [TAG_W-1:0]               line_tag,
    input  logic                           clear_all
);

    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int OFS_W   = $clog2(BLOCK_WORDS);
    localparam int DEPTH   = NUM_SETS * BLOCK_WORDS;

    logic [NUM_SETS-1:0] valid_reg;
    logic [TAG_W-1:0]    tag_reg  [NUM_SETS];
    logic [WORD_W-1:0]   data_reg [DEPTH];
    logic [NUM_SETS-1:0] set_wr;

    // One-hot decode of the set whose tag/valid is being written.
    generate
        for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set_dec
            assign set_wr[gi] = line_wr_en && (wr_index == INDEX_W'(gi));
        end
    endgenerate

    // Valid bits are the only state that must be cleared by reset; stale
    // tags and data are harmless while their valid bit is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= '0;
        end else if (clear_all) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= (valid_reg & ~set_wr) | (set_wr & {NUM_SETS{line_wr_valid}});
        end
    end

    always_ff @(posedge clk) begin
        if (line_wr_en) begin
            tag_reg[wr_index] <= line_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_reg[{wr_index, wr_ofs}] <= wr_data;
        end
    end

    assign rd_tag   = tag_reg[rd_index];
    assign rd_valid = valid_reg[rd_index];
    assign rd_data  = data_reg[{rd_index, rd_ofs}];

    logic unused_depth;
    assign unused_depth = (OFS_W + DEPTH) == 0;

endmodule

// File: rtl/ucsbece154b_icache.sv
// ----------------------------------------------------------------------------
// ucsbece154b_icache
// Direct-mapped read-only instruction cache with whole-line burst refill.
//   clk, reset      : clock, asynchronous active-low reset
//   ReadEnable      : fetch lookup request for ReadAddress
//   ReadAddress     : byte address ([1:0] ignored)
//   Flush           : invalidate every line (fence.i)
//   Instruction     : instruction word, valid while Ready=1 (0 otherwise)
//   Ready           : hit this cycle, or missed word delivered (DONE)
//   Busy            : miss in progress; fetch stalls and holds its address
//   MemReadAddress  : line-aligned refill address
//   MemReadRequest  : refill request, held until the first beat
//   MemDataIn       : refill beat data
//   MemDataReady    : MemDataIn valid
//   HitCount        : saturating hit counter
//   MissCount       : saturating miss counter
// ----------------------------------------------------------------------------
module ucsbece154b_icache
    import ucsbece154b_icache_pkg::*;
#(
    parameter int NUM_SETS    = DEF_NUM_SETS,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ReadEnable,
    input  logic [ADDR_W-1:0] ReadAddress,
    input  logic              Flush,
    output logic [WORD_W-1:0] Instruction,
    output logic              Ready,
    output logic              Busy,
    output logic [ADDR_W-1:0] MemReadAddress,
    output logic              MemReadRequest,
    input  logic [WORD_W-1:0] MemDataIn,
    input  logic              MemDataReady,
    output logic [31:0]       HitCount,
    output logic [31:0]       MissCount
);

    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int OFS_W   = $clog2(BLOCK_WORDS);
    localparam int TAG_W   = tag_width(INDEX_W, OFS_W);
    localparam int OFS_LO  = BYTE_OFS_W;
    localparam int IDX_LO  = BYTE_OFS_W + OFS_W;
    localparam int TAG_LO  = BYTE_OFS_W + OFS_W + INDEX_W;

    state_t             state_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [OFS_W-1:0]   beat_reg;
    logic               flush_pending_reg;
    logic [31:0]        hit_count_reg;
    logic [31:0]        miss_count_reg;

    logic [INDEX_W-1:0] rd_index;
    logic [OFS_W-1:0]   rd_ofs;
    logic [TAG_W-1:0]   lookup_tag;
    logic [TAG_W-1:0]   rd_tag;
    logic               rd_valid;
    logic [WORD_W-1:0]  rd_data;

    logic               in_idle;
    logic               lookup_hit;
    logic               lookup_miss;
    logic               beat_accept;
    logic               last_beat;
    logic               flush_any;
    logic               clear_all;
    logic [OFS_W-1:0]   wr_ofs;

    // In IDLE the live fetch address is looked up; otherwise the latched
    // miss address drives the array so DONE returns the filled word.
    assign in_idle    = (state_reg == IDLE);
    assign rd_index   = in_idle ? ReadAddress[IDX_LO +: INDEX_W] : addr_reg[IDX_LO +: INDEX_W];
    assign rd_ofs     = in_idle ? ReadAddress[OFS_LO +: OFS_W]   : addr_reg[OFS_LO +: OFS_W];
    assign lookup_tag = ReadAddress[TAG_LO +: TAG_W];

    assign lookup_hit  = ReadEnable && in_idle && rd_valid && (rd_tag == lookup_tag);
    assign lookup_miss = ReadEnable && in_idle && !lookup_hit;

    // A beat in REQ is always word 0; FILL uses the running beat counter.
    assign beat_accept = MemDataReady && ((state_reg == REQ) || (state_reg == FILL));
    assign wr_ofs      = (state_reg == REQ) ? '0 : beat_reg;
    assign last_beat   = (state_reg == FILL) && MemDataReady
                         && (beat_reg == OFS_W'(BLOCK_WORDS - 1));

    // A Flush coinciding with the last beat or with DONE must still leave
    // the cache empty, so the live input is folded into the pending flag.
    assign flush_any = flush_pending_reg || Flush;
    assign clear_all = (in_idle && Flush) || ((state_reg == DONE) && flush_any);

    ucsbece154b_icache_array #(
        .NUM_SETS    (NUM_SETS),
        .BLOCK_WORDS (BLOCK_WORDS),
        .TAG_W       (TAG_W)
    ) u_array (
        .clk           (clk),
        .reset         (reset),
        .rd_index      (rd_index),
        .rd_ofs        (rd_ofs),
        .rd_tag        (rd_tag),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .wr_en         (beat_accept),
        .wr_index      (addr_reg[IDX_LO +: INDEX_W]),
        .wr_ofs        (wr_ofs),
        .wr_data       (MemDataIn),
        .line_wr_en    (last_beat),
        .line_wr_valid (!flush_any),
        .line_tag      (addr_reg[TAG_LO +: TAG_W]),
        .clear_all     (clear_all)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= IDLE;
            addr_reg          <= '0;
            beat_reg          <= '0;
            flush_pending_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (lookup_miss) begin
                        addr_reg  <= ReadAddress;
                        beat_reg  <= '0;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (Flush) flush_pending_reg <= 1'b1;
                    if (MemDataReady) begin
                        beat_reg  <= OFS_W'(1);
                        state_reg <= FILL;
                    end
                end
                FILL: begin
                    if (Flush) flush_pending_reg <= 1'b1;
                    if (MemDataReady) begin
                        if (last_beat) begin
                            beat_reg  <= '0;
                            state_reg <= DONE;
                        end else begin
                            beat_reg <= beat_reg + OFS_W'(1);
                        end
                    end
                end
                DONE: begin
                    flush_pending_reg <= 1'b0;
                    state_reg         <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (lookup_hit && (hit_count_reg != 32'hFFFF_FFFF)) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
            if (lookup_miss && (miss_count_reg != 32'hFFFF_FFFF)) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

    assign Ready          = lookup_hit || (state_reg == DONE);
    assign Busy           = lookup_miss || (state_reg == REQ) || (state_reg == FILL);
    assign Instruction    = Ready ? rd_data : '0;
    assign MemReadRequest = (state_reg == REQ);
    assign MemReadAddress = {addr_reg[ADDR_W-1:IDX_LO], {IDX_LO{1'b0}}};
    assign HitCount       = hit_count_reg;
    assign MissCount      = miss_count_reg;

    // Byte-select bits never take part in a lookup.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, ReadAddress[1:0], addr_reg[1:0]};

endmodule

// File: tb/tb_ucsbece154b_icache.sv
// ----------------------------------------------------------------------------
// tb_ucsbece154b_icache
// Scoreboard bench: each request pushes its expected instruction word;
// a monitor pops and compares whenever Ready is high.
// ----------------------------------------------------------------------------
module tb_ucsbece154b_icache;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReadEnable;
    logic [31:0] ReadAddress;
    logic        Flush;
    logic [31:0] Instruction;
    logic        Ready;
    logic        Busy;
    logic [31:0] MemReadAddress;
    logic        MemReadRequest;
    logic [31:0] MemDataIn;
    logic        MemDataReady;
    logic [31:0] HitCount;
    logic [31:0] MissCount;

    always #5 clk = ~clk;

    ucsbece154b_icache dut (
        .clk            (clk),
        .reset          (reset),
        .ReadEnable     (ReadEnable),
        .ReadAddress    (ReadAddress),
        .Flush          (Flush),
        .Instruction    (Instruction),
        .Ready          (Ready),
        .Busy           (Busy),
        .MemReadAddress (MemReadAddress),
        .MemReadRequest (MemReadRequest),
        .MemDataIn      (MemDataIn),
        .MemDataReady   (MemDataReady),
        .HitCount       (HitCount),
        .MissCount      (MissCount)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_counts(input logic [31:0] h, input logic [31:0] m);
        check32("hit_count", HitCount, h);
        check32("miss_count", MissCount, m);
    endtask

    // Monitor: one line per delivered instruction.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (Ready === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ready: got Instruction 0x%08h, expected no response", Instruction);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (Instruction !== e) begin
                        n_fail++;
                        $display("FAIL instruction: got 0x%08h, expected 0x%08h", Instruction, e);
                    end else begin
                        $display("resp t=%0t instr=0x%08h ok", $time, Instruction);
                    end
                end
            end
        end
    end

    // Hit: Ready in the same cycle, no memory activity.
    task automatic do_hit(input logic [31:0] addr, input logic [31:0] exp, input logic flush);
        @(negedge clk);
        ReadEnable  = 1'b1;
        ReadAddress = addr;
        Flush       = flush;
        exp_q.push_back(exp);
        #1;
        check1("hit_ready", Ready, 1'b1);
        check1("hit_busy", Busy, 1'b0);
        check1("hit_no_req", MemReadRequest, 1'b0);
        @(negedge clk);
        ReadEnable = 1'b0;
        Flush      = 1'b0;
    endtask

    // Miss: refill with `gap` idle cycles before each beat; beat k = base+k.
    task automatic do_miss(input logic [31:0] addr, input logic [31:0] base, input int gap,
                           input bit toggle, input bit flush_mid, input logic [31:0] exp);
        @(negedge clk);
        ReadEnable   = 1'b1;
        ReadAddress  = addr;
        Flush        = 1'b0;
        MemDataReady = 1'b0;
        exp_q.push_back(exp);
        #1;
        check1("miss_busy", Busy, 1'b1);
        check1("miss_not_ready", Ready, 1'b0);
        @(negedge clk);
        if (toggle) ReadAddress = addr ^ 32'h0000_0FF0;
        #1;
        check1("req_asserted", MemReadRequest, 1'b1);
        check32("req_addr", MemReadAddress, addr & ~32'hF);
        for (int k = 0; k < 4; k++) begin
            repeat (gap) begin
                MemDataReady = 1'b0;
                Flush        = 1'b0;
                @(negedge clk);
                if (toggle) ReadAddress = ReadAddress ^ 32'h0000_0004;
                #1;
                check1("wait_busy", Busy, 1'b1);
                check1("wait_req_hold", MemReadRequest, (k == 0));
            end
            MemDataReady = 1'b1;
            MemDataIn    = base + 32'(k);
            Flush        = flush_mid && (k == 2);
            @(negedge clk);
        end
        MemDataReady = 1'b0;
        Flush        = 1'b0;
        ReadEnable   = 1'b0;
        #1;
        check1("done_ready", Ready, 1'b1);
        check1("done_busy", Busy, 1'b0);
        check1("done_no_req", MemReadRequest, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        ReadEnable   = 1'b0;
        ReadAddress  = '0;
        Flush        = 1'b0;
        MemDataIn    = '0;
        MemDataReady = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check1("rst_ready", Ready, 1'b0);
        check1("rst_busy", Busy, 1'b0);
        check1("rst_req", MemReadRequest, 1'b0);
        check32("rst_mem_addr", MemReadAddress, 32'h0);
        check32("rst_instr", Instruction, 32'h0);
        check_counts(0, 0);
        @(negedge clk);
        reset = 1'b1;

        // 1: cold miss on line 0
        do_miss(32'h00, 32'hA0, 0, 1'b0, 1'b0, 32'hA0);
        check_counts(0, 1);
        // 2: same-cycle hit
        do_hit(32'h08, 32'hA2, 1'b0);
        check_counts(1, 1);
        // 3: conflict eviction
        do_miss(32'h80, 32'hB0, 0, 1'b0, 1'b0, 32'hB0);
        do_hit(32'h8C, 32'hB3, 1'b0);
        do_miss(32'h00, 32'hA0, 0, 1'b0, 1'b0, 32'hA0);
        check_counts(2, 3);
        // 4: wait states and address toggling during Busy
        do_miss(32'h14, 32'hC0, 2, 1'b1, 1'b0, 32'hC1);
        do_hit(32'h1C, 32'hC3, 1'b0);
        check_counts(3, 4);
        // 5: flush during FILL, then same-cycle lookup with Flush, then idle flush
        do_miss(32'h24, 32'hD0, 1, 1'b0, 1'b1, 32'hD1);
        do_miss(32'h24, 32'hD0, 0, 1'b0, 1'b0, 32'hD1);
        do_hit(32'h28, 32'hD2, 1'b1);
        do_miss(32'h20, 32'hD0, 0, 1'b0, 1'b0, 32'hD0);
        check_counts(4, 7);

        // 6: reset after 2 of 4 beats
        @(negedge clk);
        ReadEnable  = 1'b1;
        ReadAddress = 32'h40;
        #1 check1("abort_miss_busy", Busy, 1'b1);
        @(negedge clk);
        MemDataReady = 1'b1;
        MemDataIn    = 32'hE0;
        @(negedge clk);
        MemDataIn    = 32'hE1;
        @(negedge clk);
        MemDataReady = 1'b0;
        ReadEnable   = 1'b0;
        reset        = 1'b0;
        #1;
        check1("abort_rst_busy", Busy, 1'b0);
        check1("abort_rst_ready", Ready, 1'b0);
        check1("abort_rst_req", MemReadRequest, 1'b0);
        check32("abort_rst_mem_addr", MemReadAddress, 32'h0);
        check_counts(0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1 check1("abort_release_busy", Busy, 1'b0);
        repeat (2) begin
            @(negedge clk);
            MemDataReady = 1'b1;
            MemDataIn    = 32'hDEAD;
            #1;
            check1("leftover_busy", Busy, 1'b0);
            check1("leftover_req", MemReadRequest, 1'b0);
        end
        @(negedge clk);
        MemDataReady = 1'b0;
        do_miss(32'h40, 32'hF0, 0, 1'b0, 1'b0, 32'hF0);
        do_hit(32'h44, 32'hF1, 1'b0);
        check_counts(1, 1);

        repeat (3) @(negedge clk);
        check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
